// File: rtl/mux_pkg.sv
// Shared constants and helpers for the channel multiplexer pipeline.
//   DEFAULT_WIDTH : default data width per channel
//   DEFAULT_N     : default number of input channels
//   clog2()       : ceiling log2 with a floor of 1, used to size select fields
package mux_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_N     = 4;

  // A select field always needs at least one bit, even for a 2-channel mux.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_nxw_comb.sv
// Purely combinational N:1 selector for a flattened channel bus.
//   in  : N*WIDTH flattened data, channel i at [i*WIDTH +: WIDTH]
//   sel : channel index; an index >= N yields all zeros
//   y   : selected channel word
module mux_nxw_comb
  import mux_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int N     = DEFAULT_N,
  localparam int SEL_W = clog2(N)
) (
  input  logic [N*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   y
);

  // NOTE: y gets a default before the loop so no path leaves it unassigned;
  // without it the tool would infer a latch for out-of-range selects.
  always_comb begin
    y = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SEL_W'(i)) y = in[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_pipe_nxw.sv
// Registered N:1 channel multiplexer with valid/ready handshakes.
// One channel, chosen by Sel, is forwarded into a registered output stage.
// Build option: define MUX_PIPE_SKID_EN for a 2-entry skid buffer whose
// InReady is driven from a register only (no combinational YReady path);
// otherwise a 1-entry stage is used with InReady = !YValid || YReady.
// Ports:
//   Clk     : clock, rising edge
//   Reset   : synchronous reset, active high
//   In      : N*WIDTH flattened channel data
//   InValid : per-channel valid
//   InReady : per-channel ready (only the selected bit can be high)
//   Sel     : channel select, used in the cycle it is presented
//   Y       : registered output word
//   YSel    : source channel of the word on Y
//   YValid  : output valid
//   YReady  : downstream ready
//   SelErr  : sticky flag, set after any cycle with Sel >= N
module mux_pipe_nxw
  import mux_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int N     = DEFAULT_N,
  localparam int SEL_W = clog2(N)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [N*WIDTH-1:0]   In,
  input  logic [N-1:0]         InValid,
  output logic [N-1:0]         InReady,
  input  logic [SEL_W-1:0]     Sel,
  output logic [WIDTH-1:0]     Y,
  output logic [SEL_W-1:0]     YSel,
  output logic                 YValid,
  input  logic                 YReady,
  output logic                 SelErr
);

  // N widened by one bit so the comparison is exact even when N == 2**SEL_W.
  localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N);

  logic [WIDTH-1:0] sel_data;
  logic             sel_ok;
  logic             stage_ready;
  logic             in_xfer;

  logic [WIDTH-1:0] y_q;
  logic [SEL_W-1:0] ysel_q;
  logic             yvalid_q;
  logic             sel_err_q;

`ifdef MUX_PIPE_SKID_EN
  logic [WIDTH-1:0] skid_data_q;
  logic [SEL_W-1:0] skid_sel_q;
  logic             skid_full_q;
`endif

  mux_nxw_comb #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_sel (
    .in  (In),
    .sel (Sel),
    .y   (sel_data)
  );

  assign sel_ok = ({1'b0, Sel} < N_LIM);

`ifdef MUX_PIPE_SKID_EN
  assign stage_ready = !skid_full_q;
`else
  assign stage_ready = !yvalid_q || YReady;
`endif

  // Only the selected channel may see ready; nothing is accepted while in
  // reset or with an out-of-range select.
  always_comb begin
    InReady = '0;
    if (sel_ok && stage_ready && !Reset) InReady = N'(1) << Sel;
  end

  // Valid of unselected channels is masked out by InReady.
  assign in_xfer = |(InValid & InReady);

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      y_q         <= '0;
      ysel_q      <= '0;
      yvalid_q    <= 1'b0;
      sel_err_q   <= 1'b0;
`ifdef MUX_PIPE_SKID_EN
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      skid_full_q <= 1'b0;
`endif
    end else begin
      if (!sel_ok) sel_err_q <= 1'b1;
`ifdef MUX_PIPE_SKID_EN
      if (skid_full_q) begin
        // Input is blocked; drain the parked word into the output stage.
        if (YReady) begin
          y_q         <= skid_data_q;
          ysel_q      <= skid_sel_q;
          skid_full_q <= 1'b0;
        end
      end else if (in_xfer) begin
        if (!yvalid_q || YReady) begin
          y_q      <= sel_data;
          ysel_q   <= Sel;
          yvalid_q <= 1'b1;
        end else begin
          // Output stalled: park the word accepted under the registered ready.
          skid_data_q <= sel_data;
          skid_sel_q  <= Sel;
          skid_full_q <= 1'b1;
        end
      end else if (YReady) begin
        yvalid_q <= 1'b0;
      end
`else
      if (in_xfer) begin
        y_q      <= sel_data;
        ysel_q   <= Sel;
        yvalid_q <= 1'b1;
      end else if (YReady) begin
        yvalid_q <= 1'b0;
      end
`endif
    end
  end

  assign Y      = y_q;
  assign YSel   = ysel_q;
  assign YValid = yvalid_q;
  assign SelErr = sel_err_q;

endmodule

// File: doc/mux_pipe_nxw.md
MUX_PIPE_NXW -- requirements
Module: mux_pipe_nxw

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width per channel in bits, legal range 1..64.
REQ-002 SHALL have parameter N, default 4: number of input channels, legal range 2..16, need not be a power of two.
REQ-003 SHALL have derived localparam SEL_W = clog2(N), minimum 1: select width.
REQ-004 SHALL have port Clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: synchronous reset, active-high.
REQ-006 SHALL have port In, input, N*WIDTH bits: flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port InValid, input, N bits: per-channel valid.
REQ-008 SHALL have port InReady, output, N bits: per-channel ready.
REQ-009 SHALL have port Sel, input, SEL_W bits: channel select, sampled in the same cycle it is used.
REQ-010 SHALL have port Y, output, WIDTH bits: registered output data.
REQ-011 SHALL have port YSel, output, SEL_W bits: source channel index of the word currently on Y.
REQ-012 SHALL have port YValid, output, 1 bit: output valid.
REQ-013 SHALL have port YReady, input, 1 bit: downstream ready.
REQ-014 SHALL have port SelErr, output, 1 bit: sticky out-of-range-select flag.

Function
REQ-015 SHALL drive InReady[i] high only when Sel == i and the output stage can accept a word; all other InReady bits SHALL be 0.
REQ-016 SHALL perform an input transfer when InValid[Sel] && InReady[Sel]; the word SHALL appear on Y, with YSel = Sel, YValid = 1, on the next rising edge (latency 1 cycle).
REQ-017 SHALL perform an output transfer when YValid && YReady; each accepted word SHALL be output exactly once, in acceptance order.
REQ-018 SHALL hold Y, YSel and YValid stable while YValid && !YReady.
REQ-019 SHALL, when input and output transfers coincide, complete both in the same cycle, giving a sustained throughput of 1 word/cycle.
REQ-020 SHALL, when Sel >= N, drive all InReady bits to 0, accept no transfer, and set SelErr on the next edge; SelErr SHALL stay at 1 until Reset.
REQ-021 SHALL have no effect from a Sel change while YValid is high on the buffered word or on YSel.
REQ-022 SHALL ignore InValid of unselected channels.

Reset
REQ-023 SHALL, with Reset high at a rising edge, clear Y = 0, YSel = 0, YValid = 0, SelErr = 0 and empty all buffer entries; Reset SHALL dominate any simultaneous transfer.
REQ-024 SHALL drive InReady all 0 during a reset cycle; a word in flight at reset SHALL be discarded.

Configuration
REQ-025 SHALL, with macro MUX_PIPE_SKID_EN defined, implement a 2-entry skid buffer and drive InReady[Sel] = !skid_full, where skid_full is a register, so that InReady has no combinational path from YReady.
REQ-026 SHALL, with MUX_PIPE_SKID_EN undefined, implement a 1-entry stage and drive InReady[Sel] = !YValid || YReady.
REQ-027 SHALL, in both variants, keep identical ordering, latency and 1 word/cycle throughput.

Structure
REQ-028 SHALL place the WIDTH/N default constants and the clog2 function in shared package mux_pkg.
REQ-029 SHALL implement combinational N:1 data selection in sub-module mux_nxw_comb (parameters WIDTH and N), instantiated once; all registers SHALL reside in mux_pipe_nxw.

Verification
REQ-030 SHALL cover basic select: N=4, WIDTH=32, Sel=2, InValid=4'b0100, In[2]=32'hDEADBEEF, YReady=1 -> next cycle Y=32'hDEADBEEF, YSel=2, YValid=1; InReady=4'b0100.
REQ-031 SHALL cover backpressure: YReady=0 for 5 cycles with word 32'h1 held -> Y stays 32'h1; InReady=0 (no skid) or accepts 1 more word and then 0 (skid); releasing YReady delivers words in order.
REQ-032 SHALL cover streaming: 16 back-to-back words 0..15 on channel 1 with YReady=1 -> Y outputs 0..15 on consecutive cycles with no bubbles.
REQ-033 SHALL cover out-of-range select: N=5, Sel=6, InValid=all 1 -> InReady=0, no YValid, SelErr=1 next cycle and held until Reset.
REQ-034 SHALL cover reset mid-operation: Reset asserted while YValid=1 and an input transfer occurs -> next cycle YValid=0, Y=0, SelErr=0, transferred word lost.
REQ-035 SHALL cover channel switching: Sel alternates 0,3,0,3 each cycle with all valid and data = channel index -> Y = 0,3,0,3 with matching YSel.
